// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter with bounded lock
// and access sequencer for the 2-bank x 4-lane byte-wide SRAM.
module sram_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic [15:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_rvalid,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic [15:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic [3:0]  bank0_cen,
  output logic [3:0]  bank1_cen,
  output logic        sram_w_en,
  output logic [12:0] sram_addr,
  output logic [31:0] sram_data,
  input  logic [7:0]  sram_q0,
  input  logic [7:0]  sram_q1,
  input  logic [7:0]  sram_q2,
  input  logic [7:0]  sram_q3,
  input  logic [7:0]  sram_q4,
  input  logic [7:0]  sram_q5,
  input  logic [7:0]  sram_q6,
  input  logic [7:0]  sram_q7
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef struct packed {
    logic       vld;
    logic       port;
    logic       bank;
    logic [3:0] mask;
  } rd_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t      state_q;
  state_t      state_d;
  logic        last_q;
  logic [7:0]  lock_cnt_q;
  logic [7:0]  lock_cnt_d;

  logic        own0;
  logic        own1;
  logic        owner_lock;
  logic        hold;
  logic        gnt0;
  logic        gnt1;
  logic        acc;

  logic        sel_write;
  logic [15:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [3:0]  lane_mask;

  rd_t         rd1_q;
  rd_t         rd1_d;
  rd_t         rv_q;
  logic [31:0] lane_q;
  logic [31:0] lane_m;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign owner_lock = (own0 & m0_lock) | (own1 & m1_lock);
  assign hold = owner_lock & (lock_cnt_q < LOCK_MAX);

  // state, round-robin pointer and lock counter registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      if (acc) last_q <= gnt1;
    end
  end

  // owner tracking: the port granted this cycle owns the next one
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      gnt0:    state_d = OWN0;
      gnt1:    state_d = OWN1;
      default: state_d = IDLE;
    endcase
  end

  // grant: lone requester wins, locked owner keeps it while under
  // the bound, otherwise the port that did not win last time
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (m0_valid & ~m1_valid): gnt0 = 1'b1;
      (m1_valid & ~m0_valid): gnt1 = 1'b1;
      (m0_valid & m1_valid & hold): begin
        gnt0 = own0;
        gnt1 = own1;
      end
      (m0_valid & m1_valid & ~hold): begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end
      default: ;
    endcase
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;
  assign acc = gnt0 | gnt1;

  // count re-grants to a locking owner, saturating at the bound
  always_comb begin
    lock_cnt_d = 8'd0;
    if (((gnt0 & own0) | (gnt1 & own1)) & owner_lock) begin
      if (lock_cnt_q == LOCK_MAX) lock_cnt_d = lock_cnt_q;
      else lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  // request mux for the accepted port
  always_comb begin
    sel_write = m0_write;
    sel_addr  = m0_addr;
    sel_size  = m0_size;
    sel_wdata = m0_wdata;
    if (gnt1) begin
      sel_write = m1_write;
      sel_addr  = m1_addr;
      sel_size  = m1_size;
      sel_wdata = m1_wdata;
    end
  end

  // byte lanes touched by the access
  always_comb begin
    lane_mask = 4'hF;
    unique case (sel_size)
      2'b00: lane_mask = 4'b0001 << sel_addr[1:0];
      2'b01: lane_mask = sel_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'hF;
    endcase
  end

  // SRAM control launch; idle cycles park cen and w_en high
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      bank0_cen <= 4'hF;
      bank1_cen <= 4'hF;
      sram_w_en <= 1'b1;
      sram_addr <= 13'd0;
      sram_data <= 32'd0;
    end else begin
      bank0_cen <= 4'hF;
      bank1_cen <= 4'hF;
      sram_w_en <= 1'b1;
      if (acc) begin
        if (sel_addr[15]) bank1_cen <= ~lane_mask;
        else bank0_cen <= ~lane_mask;
        sram_w_en <= ~sel_write;
        sram_addr <= sel_addr[14:2];
        sram_data <= sel_wdata;
      end
    end
  end

  assign rd1_d = '{
    vld:  acc & ~sel_write,
    port: gnt1,
    bank: sel_addr[15],
    mask: lane_mask
  };

  // read tag pipeline: launch stage, then return stage
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd1_q <= '0;
      rv_q  <= '0;
    end else begin
      rd1_q <= rd1_d;
      rv_q  <= rd1_q;
    end
  end

  assign lane_q = rv_q.bank ?
    {sram_q7, sram_q6, sram_q5, sram_q4} :
    {sram_q3, sram_q2, sram_q1, sram_q0};

  assign lane_m = {
    {8{rv_q.mask[3]}}, {8{rv_q.mask[2]}},
    {8{rv_q.mask[1]}}, {8{rv_q.mask[0]}}
  };

  assign rdata = rv_q.vld ? (lane_q & lane_m) : 32'd0;
  assign m0_rvalid = rv_q.vld & ~rv_q.port;
  assign m1_rvalid = rv_q.vld & rv_q.port;

  a_one_grant: assert property (
    @(posedge hclk) disable iff (!hresetn)
    !(m0_ready && m1_ready)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench with a byte-level reference model
// of arbitration, SRAM launch and read return.
module tb_sram_arbiter;

  localparam int MAXL = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        m0_valid, m0_write, m0_lock;
  logic [15:0] m0_addr;
  logic [1:0]  m0_size;
  logic [31:0] m0_wdata;
  logic        m1_valid, m1_write, m1_lock;
  logic [15:0] m1_addr;
  logic [1:0]  m1_size;
  logic [31:0] m1_wdata;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic [3:0]  bank0_cen, bank1_cen;
  logic        sram_w_en;
  logic [12:0] sram_addr;
  logic [31:0] sram_data;
  logic [7:0]  q [8];

  int n_chk = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  sram_arbiter #(.MAX_LOCK(MAXL)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(m1_ready),
    .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .bank0_cen(bank0_cen), .bank1_cen(bank1_cen),
    .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_data(sram_data),
    .sram_q0(q[0]), .sram_q1(q[1]), .sram_q2(q[2]),
    .sram_q3(q[3]), .sram_q4(q[4]), .sram_q5(q[5]),
    .sram_q6(q[6]), .sram_q7(q[7])
  );

  // SRAM core: eight byte lanes sampling controls on the clock edge
  logic [7:0] core [8][8192];
  always @(posedge hclk) begin
    for (int l = 0; l < 8; l++) begin
      automatic logic [3:0] c = (l < 4) ? bank0_cen : bank1_cen;
      if (!c[l % 4]) begin
        if (!sram_w_en) core[l][sram_addr] <= sram_data[(l % 4) * 8 +: 8];
        else q[l] <= core[l][sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  int owner, last, cnt, cg;
  logic [7:0]  mem [2][8192][4];
  logic [3:0]  e_cen0, e_cen1;
  logic        e_wen;
  logic [12:0] e_addr;
  logic [31:0] e_data;
  logic        p1_v, p2_v;
  int          p1_port, p2_port;
  logic [31:0] p1_d, p2_d;

  function automatic logic [3:0] lanes(input logic [1:0] sz,
                                       input logic [1:0] lo);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'b00) m[i] = (i == int'(lo));
      else if (sz == 2'b01) m[i] = ((i / 2) == int'(lo[1]));
      else m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int pick();
    if (m0_valid && !m1_valid) return 0;
    if (m1_valid && !m0_valid) return 1;
    if (!m0_valid) return -1;
    if (owner >= 0 && (owner == 0 ? m0_lock : m1_lock) && cnt < MAXL)
      return owner;
    return 1 - last;
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; cnt = 0;
    e_cen0 = 4'hF; e_cen1 = 4'hF; e_wen = 1'b1;
    e_addr = '0; e_data = '0;
    p1_v = 1'b0; p2_v = 1'b0;
    p1_port = 0; p2_port = 0; p1_d = '0; p2_d = '0;
  endtask

  task automatic model_step(input int g);
    logic [15:0] a;
    logic [1:0]  sz;
    logic        w, lk;
    logic [31:0] wd;
    logic [3:0]  m;
    int b, wi;
    p2_v = p1_v; p2_port = p1_port; p2_d = p1_d;
    p1_v = 1'b0;
    e_cen0 = 4'hF; e_cen1 = 4'hF; e_wen = 1'b1;
    if (g < 0) begin
      owner = -1; cnt = 0;
      return;
    end
    a  = (g == 1) ? m1_addr  : m0_addr;
    sz = (g == 1) ? m1_size  : m0_size;
    w  = (g == 1) ? m1_write : m0_write;
    wd = (g == 1) ? m1_wdata : m0_wdata;
    lk = (g == 1) ? m1_lock  : m0_lock;
    m  = lanes(sz, a[1:0]);
    b  = int'(a[15]);
    wi = int'(a[14:2]);
    if (b == 0) e_cen0 = ~m; else e_cen1 = ~m;
    e_wen = ~w; e_addr = a[14:2]; e_data = wd;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) mem[b][wi][i] = wd[8 * i +: 8];
    end else begin
      p1_v = 1'b1; p1_port = g; p1_d = '0;
      for (int i = 0; i < 4; i++)
        if (m[i]) p1_d[8 * i +: 8] = mem[b][wi][i];
    end
    if (g == owner && lk) cnt = (cnt < MAXL) ? cnt + 1 : cnt;
    else cnt = 0;
    owner = g; last = g;
  endtask

  // compare every cycle on the falling edge, then advance the model
  always @(negedge hclk) begin
    if (!hresetn) begin
      model_reset();
      chk("rst_cen", {bank1_cen, bank0_cen}, 32'hFF);
      chk("rst_wen", sram_w_en, 1'b1);
      chk("rst_rv", {m1_rvalid, m0_rvalid}, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
    end else begin
      cg = pick();
      chk("m0_ready", m0_ready, cg == 0);
      chk("m1_ready", m1_ready, cg == 1);
      chk("bank0_cen", bank0_cen, e_cen0);
      chk("bank1_cen", bank1_cen, e_cen1);
      chk("sram_w_en", sram_w_en, e_wen);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_data", sram_data, e_data);
      chk("m0_rvalid", m0_rvalid, p2_v && p2_port == 0);
      chk("m1_rvalid", m1_rvalid, p2_v && p2_port == 1);
      chk("rdata", rdata, p2_v ? p2_d : 32'h0);
      model_step(cg);
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    m0_valid = 0; m1_valid = 0; m0_lock = 0; m1_lock = 0;
  endtask

  task automatic drv(input int p, input logic w, input logic [15:0] a,
                     input logic [1:0] sz, input logic [31:0] d,
                     input logic lk);
    if (p == 0) begin
      m0_valid = 1; m0_write = w; m0_addr = a;
      m0_size = sz; m0_wdata = d; m0_lock = lk;
    end else begin
      m1_valid = 1; m1_write = w; m1_addr = a;
      m1_size = sz; m1_wdata = d; m1_lock = lk;
    end
  endtask

  logic [5:0] lock_seq;

  initial begin
    lock_seq = 6'b101111;
    idle();
    m0_write = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
    m1_write = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
    hresetn = 1'b1;
    #1 hresetn = 1'b0;
    #1;
    chk("init_cen", {bank1_cen, bank0_cen}, 32'hFF);
    chk("init_wen", sram_w_en, 1'b1);
    chk("init_addr", sram_addr, 13'h0);
    chk("init_data", sram_data, 32'h0);
    chk("init_rv", {m1_rvalid, m0_rvalid}, 2'b00);
    step();
    step();
    hresetn = 1'b1;

    // word write then word read, port 0
    drv(0, 1, 16'h0010, 2'b10, 32'hDEADBEEF, 0);
    #1 chk("wr_ready", m0_ready, 1'b1);
    step();
    chk("wr_cen", {bank1_cen, bank0_cen}, 32'hF0);
    chk("wr_addr", sram_addr, 13'h004);
    chk("wr_wen", sram_w_en, 1'b0);
    chk("wr_data", sram_data, 32'hDEADBEEF);
    drv(0, 0, 16'h0010, 2'b10, 32'h0, 0);
    step();
    idle();
    chk("rd_wen", sram_w_en, 1'b1);
    chk("rd_early", m0_rvalid, 1'b0);
    step();
    chk("rd_rvalid", m0_rvalid, 1'b1);
    chk("rd_data", rdata, 32'hDEADBEEF);
    step();
    chk("rd_once", m0_rvalid, 1'b0);

    // bank 1 byte and half lanes, port 1
    drv(1, 1, 16'h8000, 2'b10, 32'h11223344, 0);
    step();
    chk("b1w_cen", {bank1_cen, bank0_cen}, 32'h0F);
    drv(1, 0, 16'h8003, 2'b00, 32'h0, 0);
    step();
    chk("byte_cen1", bank1_cen, 4'h7);
    chk("byte_cen0", bank0_cen, 4'hF);
    drv(1, 0, 16'h8001, 2'b01, 32'h0, 0);
    step();
    chk("half_cen1", bank1_cen, 4'hC);
    chk("byte_rv", m1_rvalid, 1'b1);
    chk("byte_rdata", rdata, 32'h11000000);
    idle();
    step();
    chk("half_rdata", rdata, 32'h00003344);

    // idle power
    for (int i = 0; i < 3; i++) begin
      chk("idle_cen", {bank1_cen, bank0_cen}, 32'hFF);
      chk("idle_wen", sram_w_en, 1'b1);
      step();
    end

    // round-robin, no lock
    drv(0, 0, 16'h0010, 2'b10, 32'h0, 0);
    drv(1, 0, 16'h8000, 2'b10, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_grant0", m0_ready, (i % 2) == 0);
      step();
    end
    idle();
    repeat (3) step();

    // lock bound
    drv(1, 1, 16'h8004, 2'b10, 32'hCAFE0001, 1);
    #1 chk("lk_alone", m1_ready, 1'b1);
    step();
    drv(0, 0, 16'h0010, 2'b10, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      #1 chk("lk_grant1", m1_ready, lock_seq[i]);
      step();
    end
    idle();
    repeat (3) step();

    // reset mid-read
    drv(0, 0, 16'h0010, 2'b10, 32'h0, 0);
    step();
    idle();
    #1 chk("pre_rst_cen", bank0_cen, 4'h0);
    hresetn = 1'b0;
    #1;
    chk("mid_rst_cen", {bank1_cen, bank0_cen}, 32'hFF);
    chk("mid_rst_wen", sram_w_en, 1'b1);
    chk("mid_rst_rv", m0_rvalid, 1'b0);
    step();
    hresetn = 1'b1;
    chk("rst_drop_rv", m0_rvalid, 1'b0);
    drv(0, 0, 16'h0010, 2'b10, 32'h0, 0);
    drv(1, 0, 16'h8000, 2'b10, 32'h0, 0);
    #1;
    chk("post_rst_g0", m0_ready, 1'b1);
    chk("post_rst_g1", m1_ready, 1'b0);
    step();
    idle();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
